// File: rtl/md_sequencer_if.sv
// Decode-stage <-> multiply/divide sequencer bundle: launch strobe, operands, busy and HI/LO.
interface md_sequencer_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDOp, A, B, input Busy, HI, LO);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer: results are computed at launch, held in phi/plo,
// and committed to HI/LO on the edge that ends the fixed-length busy window.
module md_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic           clk,
    input logic           reset,
    md_sequencer_if.slave md
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_q, lo_q, phi, plo;
    logic [31:0]   res_hi, res_lo;

    logic [63:0] sprod, uprod;
    logic [31:0] a_mag, b_mag, div_n, div_d, q_mag, r_mag;
    logic        signed_div;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 deterministically.
    always_comb begin
        sprod      = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
        uprod      = {32'b0, md.A} * {32'b0, md.B};
        signed_div = (md.MDOp == OP_DIV);
        a_mag      = md.A[31] ? (32'd0 - md.A) : md.A;
        b_mag      = md.B[31] ? (32'd0 - md.B) : md.B;
        div_n      = signed_div ? a_mag : md.A;
        div_d      = signed_div ? b_mag : md.B;
        q_mag      = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
        r_mag      = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
        res_hi     = hi_q;
        res_lo     = lo_q;
        case (md.MDOp)
            OP_MULT:  {res_hi, res_lo} = sprod;
            OP_MULTU: {res_hi, res_lo} = uprod;
            OP_DIV: if (md.B != 32'd0) begin
                res_lo = (md.A[31] ^ md.B[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi = md.A[31] ? (32'd0 - r_mag) : r_mag;
            end
            OP_DIVU: if (md.B != 32'd0) begin
                res_lo = q_mag;
                res_hi = r_mag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            phi   <= '0;
            plo   <= '0;
        end else if (state == S_RUN) begin
            // Start is deliberately not looked at here, including on the completion edge.
            if (cnt == CNT_ONE) begin
                hi_q  <= phi;
                lo_q  <= plo;
                cnt   <= '0;
                state <= S_IDLE;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end else if (md.Start) begin
            case (md.MDOp)
                OP_MULT, OP_MULTU: begin
                    phi   <= res_hi;
                    plo   <= res_lo;
                    cnt   <= MUL_LD;
                    state <= S_RUN;
                end
                OP_DIV, OP_DIVU: begin
                    phi   <= res_hi;
                    plo   <= res_lo;
                    cnt   <= DIV_LD;
                    state <= S_RUN;
                end
                OP_MTHI: hi_q <= md.A;
                OP_MTLO: lo_q <= md.A;
                default: ;
            endcase
        end
    end

    assign md.Busy = (state == S_RUN);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 5: Busy duration, in cycles, of mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: Busy duration, in cycles, of div/divu.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  one-cycle launch strobe from the decode stage.
REQ-006 MDOp  input  3  operation select: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved.
REQ-007 A  input  32  rs operand, already forwarded.
REQ-008 B  input  32  rt operand, already forwarded.
REQ-009 Busy  output  1  unit occupied; the decode stage stalls md-class instructions while it is high.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.

Function
REQ-012 The block SHALL implement a state machine with states IDLE and RUN, plus a down-counter cnt.
- Counter width: ceil(log2(max(MUL_CYCLES, DIV_CYCLES)+1)) bits.
REQ-013 In IDLE, Start=1 with MDOp in {001..100} SHALL do all of the following at that edge:
- compute the result into pending registers phi/plo;
- load cnt with MUL_CYCLES or DIV_CYCLES;
- enter RUN.
REQ-014 In RUN, each edge SHALL decrement cnt.
- When cnt==1 at an edge: HI<=phi, LO<=plo, cnt<=0, state<=IDLE, all in that same edge.
REQ-015 Busy SHALL be combinational (state==RUN).
- Busy is therefore high for exactly MUL_CYCLES or DIV_CYCLES cycles, starting the cycle after Start.
REQ-016 HI/LO SHALL remain unchanged throughout RUN; new values become visible in the first cycle with Busy=0.
REQ-017 mult SHALL form the signed 64-bit product A*B; multu SHALL form the unsigned product; {HI,LO} = product.
REQ-018 div SHALL compute the signed quotient truncated toward zero into LO and the remainder into HI.
- The remainder takes the sign of the dividend.
REQ-019 divu SHALL compute the unsigned quotient into LO and the remainder into HI.
REQ-020 Signed div of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-021 Division by zero (B==0, div or divu) SHALL still occupy RUN for DIV_CYCLES cycles.
- On completion HI and LO SHALL keep their pre-operation values.
REQ-022 mthi/mtlo with Start=1 in IDLE SHALL write A into HI or LO at that edge.
- Busy SHALL stay 0; the other register is unchanged.
REQ-023 Start=1 during RUN SHALL be ignored entirely (all opcodes); the decode stage guarantees this does not occur.
REQ-024 Start=1 with MDOp 000 or 111 SHALL have no effect.
REQ-025 Start on the same edge that completes RUN SHALL be ignored.
- It is sampled while the state is still RUN.
- It is accepted on the next edge, if it is still asserted.
REQ-026 Start=0 SHALL never change state, regardless of MDOp.

Reset
REQ-027 While reset==0, the block SHALL asynchronously force: state=IDLE, cnt=0, Busy=0, HI=0, LO=0, phi=0, plo=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no result is ever committed.
REQ-029 After reset deasserts, the first rising edge SHALL be able to accept Start.

Verification
REQ-030 mult, A=0xFFFFFFFE (-2), B=3, Start one cycle:
- Busy=1 for exactly 5 cycles;
- then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 div, A=-7 (0xFFFFFFF9), B=2:
- Busy for 10 cycles;
- then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Repeat as divu with A=7, B=2 -> LO=3, HI=1.
REQ-033 mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles:
- Busy stays 0;
- HI/LO are updated one edge after each strobe.
REQ-034 Boundary cases:
- div with B=0 after HI=0xAAAA, LO=0x5555 -> 10 Busy cycles, HI/LO unchanged.
- Start of a mult during RUN -> ignored.
- Start on the completion edge -> ignored.
REQ-035 Reset pulled low at cycle 3 of a div:
- Busy drops to 0 immediately and HI=LO=0;
- no later commit occurs.
